fetch: RTL and testbench

- Instruction-fetch stage of the RISC-V core.
- Holds a 2^ADDR_WIDTH x DATA_WIDTH instruction memory, loaded word-by-word through a controller write port.
- Holds the program counter (word-addressed).
- On each controller fetch request, reads one instruction from an address picked by pc_sel and returns it one cycle later with a valid strobe.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_imem.sv | 42 ++++
 rtl/fetch.sv | 92 +++++++++
 tb/tb_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: pc_sel encodings and
// default memory geometry.
package fetch_pkg;

    // Default geometry: 2048 words of 32-bit instructions.
    localparam int FETCH_ADDR_WIDTH = 11;
    localparam int FETCH_DATA_WIDTH = 32;

    // Next-fetch address select encodings.
    localparam logic [1:0] PCSEL_SEQ  = 2'b00;  // fetch at pc
    localparam logic [1:0] PCSEL_IMM  = 2'b01;  // fetch at imm_addr
    localparam logic [1:0] PCSEL_ALU  = 2'b10;  // fetch at alu_addr
    localparam logic [1:0] PCSEL_HOLD = 2'b11;  // replay pc, pc not advanced

endpackage : fetch_pkg

// File: rtl/fetch_imem.sv
// Instruction memory: simple dual-port RAM, one synchronous write port and
// one synchronous read-first read port with an enabled, resettable output
// register. Memory contents are never reset.
module fetch_imem #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: one word per cycle, also active during reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: read-first, so a same-address write this edge is not seen;
    // output register clears on reset and holds when not reading.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_raddr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : fetch_imem

// File: rtl/fetch.sv
// Instruction-fetch stage: program counter, next-fetch address mux and the
// instruction memory. Each fetch request returns one word a cycle later.
//
// Output strobe: cntlr_rd_valid is high for exactly one cycle per accepted
// request (the cycle after the request edge); cntlr_rd_data is meaningful only
// while it is high. There is no back-pressure: a request is accepted on every
// rising edge where cntlr_rd=1 and rst=0, so back-to-back requests keep the
// strobe high continuously.
module fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [ADDR_WIDTH-1:0] imm_addr,
    input  logic                  cntlr_rd,
    output logic [DATA_WIDTH-1:0] cntlr_rd_data,
    output logic                  cntlr_rd_valid,
    input  logic                  cntlr_wr,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_rd_valid;
    logic [ADDR_WIDTH-1:0] w_fa;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_fetch;

    // A request in a reset cycle is dropped.
    assign w_fetch = cntlr_rd && !rst;

    // Fetch address mux: replay and sequential both read at the current pc.
    always_comb begin
        w_fa = r_pc;
        case (pc_sel)
            PCSEL_SEQ:  w_fa = r_pc;
            PCSEL_IMM:  w_fa = imm_addr;
            PCSEL_ALU:  w_fa = alu_addr;
            PCSEL_HOLD: w_fa = r_pc;
            default:    w_fa = r_pc;
        endcase
    end

    // Next pc: one past the fetched word (wrapping modulo the memory depth),
    // except replay which leaves pc where it is.
    always_comb begin
        w_pc_next = w_fa + ADDR_WIDTH'(1);
        if (pc_sel == PCSEL_HOLD) begin
            w_pc_next = r_pc;
        end
    end

    // PC register: advances only on accepted fetch requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (w_fetch) begin
            r_pc <= w_pc_next;
        end
    end

    // Valid strobe: one cycle after each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= cntlr_rd;
        end
    end

    fetch_imem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imem (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (cntlr_wr),
        .i_waddr   (cntlr_waddr),
        .i_wdata   (cntlr_wr_data),
        .i_rd_en   (w_fetch),
        .i_raddr   (w_fa),
        .o_rd_data (cntlr_rd_data)
    );

    assign cntlr_rd_valid = r_rd_valid;

endmodule : fetch

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage. Returned words are matched against an
// expected queue filled by the driver tasks; strobe timing and pc are checked
// directly after each edge.
module tb_fetch;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    pc_sel;
    logic [AW-1:0] alu_addr;
    logic [AW-1:0] imm_addr;
    logic          cntlr_rd;
    logic [DW-1:0] cntlr_rd_data;
    logic          cntlr_rd_valid;
    logic          cntlr_wr;
    logic [AW-1:0] cntlr_waddr;
    logic [DW-1:0] cntlr_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_sel         (pc_sel),
        .alu_addr       (alu_addr),
        .imm_addr       (imm_addr),
        .cntlr_rd       (cntlr_rd),
        .cntlr_rd_data  (cntlr_rd_data),
        .cntlr_rd_valid (cntlr_rd_valid),
        .cntlr_wr       (cntlr_wr),
        .cntlr_waddr    (cntlr_waddr),
        .cntlr_wr_data  (cntlr_wr_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single checking task
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (cntlr_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'b0, cntlr_rd_valid}, 32'd0);
            end else begin
                check("rd_data", cntlr_rd_data, exp_q.pop_front());
            end
        end
    end

    // Driver tasks: inputs change on the falling edge, outputs are read 1ns
    // after the following rising edge.
    task automatic idle_cycle();
        @(negedge clk);
        cntlr_rd = 1'b0;
        cntlr_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cntlr_rd      = 1'b0;
        cntlr_wr      = 1'b1;
        cntlr_waddr   = a;
        cntlr_wr_data = d;
        @(posedge clk);
        #1;
    endtask

    // One request cycle (optionally with a write), then checks the strobe.
    task automatic req(input logic [1:0] sel, input logic [AW-1:0] imm, input logic [AW-1:0] alu,
                       input logic [DW-1:0] exp, input logic wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        @(negedge clk);
        cntlr_rd      = 1'b1;
        pc_sel        = sel;
        imm_addr      = imm;
        alu_addr      = alu;
        cntlr_wr      = wr;
        cntlr_waddr   = wa;
        cntlr_wr_data = wd;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check("valid_hi", {31'b0, cntlr_rd_valid}, 32'd1);
    endtask

    // Isolated fetch: request, then one idle cycle where the strobe must drop.
    task automatic fetch1(input logic [1:0] sel, input logic [AW-1:0] imm, input logic [AW-1:0] alu,
                          input logic [DW-1:0] exp);
        req(sel, imm, alu, exp, 1'b0, '0, '0);
        idle_cycle();
        check("valid_lo", {31'b0, cntlr_rd_valid}, 32'd0);
    endtask

    task automatic check_pc(input string tag, input logic [AW-1:0] exp);
        check(tag, {21'b0, dut.r_pc}, {21'b0, exp});
    endtask

    initial begin
        // Reset with a request and a write pending: request dropped, write kept
        rst           = 1'b1;
        cntlr_rd      = 1'b1;
        pc_sel        = 2'b01;
        imm_addr      = 11'd5;
        alu_addr      = 11'd0;
        cntlr_wr      = 1'b1;
        cntlr_waddr   = 11'd0;
        cntlr_wr_data = 32'h0BAD0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, cntlr_rd_valid}, 32'd0);
        check("rst_data", cntlr_rd_data, 32'd0);
        check_pc("rst_pc", 11'd0);
        @(negedge clk);
        rst = 1'b0;
        cntlr_rd = 1'b0;
        cntlr_wr = 1'b0;

        // Load program words
        write_word(11'd4,    32'hA5A50004);
        write_word(11'd5,    32'hA5A50001);
        write_word(11'd6,    32'hA5A50002);
        write_word(11'd7,    32'hA5A50003);
        write_word(11'd8,    32'hA5A50008);
        write_word(11'd2047, 32'h7FF7FF00);
        idle_cycle();
        check("load_no_valid", {31'b0, cntlr_rd_valid}, 32'd0);
        check_pc("load_pc", 11'd0);

        // Immediate-target fetches
        fetch1(2'b01, 11'd5, 11'd0, 32'hA5A50001);
        fetch1(2'b01, 11'd6, 11'd0, 32'hA5A50002);
        fetch1(2'b01, 11'd6, 11'd0, 32'hA5A50002);
        fetch1(2'b01, 11'd7, 11'd0, 32'hA5A50003);
        check_pc("imm_pc", 11'd8);

        // Sequential fetch after a jump to 5
        fetch1(2'b01, 11'd5, 11'd0, 32'hA5A50001);
        check_pc("seq_pc0", 11'd6);
        fetch1(2'b00, 11'd0, 11'd0, 32'hA5A50002);
        fetch1(2'b00, 11'd0, 11'd0, 32'hA5A50003);
        check_pc("seq_pc", 11'd8);

        // ALU target, then replay twice at pc=8
        fetch1(2'b10, 11'd0, 11'd7, 32'hA5A50003);
        check_pc("alu_pc", 11'd8);
        fetch1(2'b11, 11'd3, 11'd3, 32'hA5A50008);
        fetch1(2'b11, 11'd3, 11'd3, 32'hA5A50008);
        check_pc("hold_pc", 11'd8);

        // Same-address collision is read-first
        req(2'b01, 11'd5, 11'd0, 32'hA5A50001, 1'b1, 11'd5, 32'hDEADBEEF);
        idle_cycle();
        fetch1(2'b01, 11'd5, 11'd0, 32'hDEADBEEF);

        // Read and write to different addresses in one cycle
        req(2'b01, 11'd6, 11'd0, 32'hA5A50002, 1'b1, 11'd9, 32'h00000009);
        idle_cycle();
        fetch1(2'b00, 11'd0, 11'd0, 32'hA5A50003);
        fetch1(2'b00, 11'd0, 11'd0, 32'hA5A50008);
        fetch1(2'b00, 11'd0, 11'd0, 32'h00000009);

        // PC wrap-around from the last word
        fetch1(2'b10, 11'd0, 11'd2047, 32'h7FF7FF00);
        check_pc("wrap_pc0", 11'd0);
        fetch1(2'b00, 11'd0, 11'd0, 32'h0BAD0000);
        check_pc("wrap_pc1", 11'd1);

        // Idle: strobe low, data and pc hold
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check("idle_valid", {31'b0, cntlr_rd_valid}, 32'd0);
            check("idle_data", cntlr_rd_data, 32'h0BAD0000);
        end
        check_pc("idle_pc", 11'd1);

        // Back-to-back sequential from pc=5
        fetch1(2'b01, 11'd4, 11'd0, 32'hA5A50004);
        check_pc("b2b_pc0", 11'd5);
        req(2'b00, 11'd0, 11'd0, 32'hDEADBEEF, 1'b0, '0, '0);
        req(2'b00, 11'd0, 11'd0, 32'hA5A50002, 1'b0, '0, '0);
        req(2'b00, 11'd0, 11'd0, 32'hA5A50003, 1'b0, '0, '0);
        idle_cycle();
        check("b2b_valid_lo", {31'b0, cntlr_rd_valid}, 32'd0);
        check_pc("b2b_pc", 11'd8);

        // All expectations must have been consumed
        idle_cycle();
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch
